forward_hazard_unit: RTL and testbench
======================================

# forward_hazard_unit

Operand-forwarding and load-use hazard controller for the integer pipeline. It keeps a shadow copy of destination-register information for the EX, MEM and WB stages. From that copy it produces registered 2-bit selects for the two execute-stage 4:1 operand muxes, a load-use stall request for fetch/decode, and a bubble-valid flag for EX. It sits between the decode stage and the execute-stage operand muxes and acts as their select source.

## Interface
- R, 4, register address width (2^R architectural registers)
- ZERO_HARD, 1, register 0 is hardwired zero and never matches a producer
- CW, 16, width of the stall performance counter
- clk  in  1  pipeline clock
- rst  in  1  reset, asynchronous, active-low
- rs1_id, rs2_id  in  R  source registers of the instruction in ID
- rs1_use_id, rs2_use_id  in  1  the instruction in ID actually reads that source
- use_imm_id  in  1  operand B is the immediate
- rd_id  in  R  destination register of the instruction in ID
- we_id  in  1  the instruction in ID writes rd_id
- load_id  in  1  the instruction in ID is a load
- valid_id  in  1  ID holds a real instruction
- stall_ext  in  1  global freeze (memory wait); everything holds
- flush  in  1  taken branch resolved; the instruction entering EX becomes a bubble
- sel_a, sel_b  out  2  operand mux selects for the instruction now in EX
- stall_id  out  1  hold PC and IF/ID (combinational)
- ex_valid  out  1  EX holds a real instruction
- stall_cnt  out  CW  saturating count of load-use stall cycles

## Operation
- Select encoding (hazard_pkg): 00 SEL_REG = ID/EX register value; 01 SEL_EXMEM = EX/MEM ALU result; 10 SEL_MEMWB = MEM/WB result or load data; 11 SEL_IMM = immediate (sel_b only).
- sel_a never takes 11.
- Shadow slots ex, mem, wb each hold {valid, rd, we, load}.
- A slot "matches" source s when all hold: valid, we, rd==s, the source is used, and not (ZERO_HARD and s==0).
- The register file is write-through. A producer in WB never needs forwarding.
- The decision is computed in ID and registered into sel_a/sel_b on the advancing edge:
  - the ex slot matches: SEL_EXMEM (the producer will be in MEM next cycle);
  - else the mem slot matches: SEL_MEMWB;
  - else SEL_REG.
  - The ex slot has priority because it is the youngest producer.
  - For sel_b, use_imm_id overrides everything with SEL_IMM.
- Load-use: stall_id = valid_id and not stall_ext and the ex slot matches with load=1, for rs1, or for rs2 when not use_imm_id.
- Edge behaviour, in priority order:
  - rst low: all slots invalid, sel_a=sel_b=00, ex_valid=0, stall_cnt=0.
  - stall_ext: every slot, select, ex_valid and stall_cnt holds. flush is ignored.
  - flush: the ex slot loads a bubble with sel 00 and ex_valid=0. mem←ex and wb←mem shift normally. No stall counting.
  - stall_id: same as flush (bubble into EX, shift mem/wb). stall_cnt increments and saturates at 2^CW−1.
  - normal: ex←{valid_id, rd_id, we_id, load_id}, mem←ex, wb←mem. sel_a/sel_b take the computed values. ex_valid←valid_id.
- Invalid ID (valid_id=0) advances as a bubble with sel 00.

## Timing
- stall_id is combinational from ID inputs and the ex slot in the same cycle. It is low whenever stall_ext=1.
- sel_a, sel_b and ex_valid are registered, with one edge of latency from ID. They are stable for the whole EX cycle and feed the mux select directly.
- A load followed by a dependent instruction costs exactly 1 stall cycle. After the stall, the dependent instruction gets SEL_MEMWB.
- Back-to-back ALU dependency: 0 stall cycles, SEL_EXMEM.
- Reset is asynchronous on assertion. All outputs are at their reset values within the same cycle.
- Deassertion is synchronised externally. The first active edge behaves as normal.
- When stall_ext deasserts, operation resumes from the held state with no lost or duplicated slot.

## Structure
- hazard_pkg holds:
  - the sel_t encoding constants SEL_REG, SEL_EXMEM, SEL_MEMWB, SEL_IMM;
  - the slot_t struct {valid, rd, we, load}, parameterised through a localparam matching R;
  - the function slot_match(slot_t, src, use).
- One sub-module, hazard_slot: a slot_t register with async active-low clear, hold enable and bubble-load. It is instantiated three times (ex, mem, wb).
- The top level holds the match logic, the select and stall generation, and the counter.

## Test plan
- ADD x3 then SUB x5,x3,x4 (rs1=3): sel_a=01, sel_b=00, stall_id never asserted.
- ADD x3, NOP, then OR x6,x1,x3: sel_b=10, sel_a=00.
- LW x7 then ADD x8,x7,x2: stall_id=1 for exactly 1 cycle, ex_valid=0 in the bubble cycle, then sel_a=10; stall_cnt goes 0→1.
- Writes to x0 in EX and MEM followed by a reader of x0 (ZERO_HARD=1): sel_a=00. Two producers of x9 in EX and MEM with a reader of x9: sel=01 (youngest wins). use_imm_id=1 with a matching rs2: sel_b=11.
- stall_ext held 3 cycles during a pending load-use: outputs frozen and stall_id=0. After release, exactly 1 stall occurs. Flush asserted together with stall_ext has no effect. Flush alone: ex_valid=0, sel 00.
- rst pulled low mid-stream with stall_cnt=5 and slots valid: all outputs are 0 immediately, without a clock edge. Force stall_cnt to 2^CW−1, then issue a further load-use: the counter stays saturated.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the forwarding / load-use hazard controller: operand
// select encoding, the shadow slot record and the slot match helper.
package hazard_pkg;

  localparam int REG_W = 4;

  typedef enum logic [1:0] {
    SEL_REG   = 2'b00,  // ID/EX register value
    SEL_EXMEM = 2'b01,  // EX/MEM ALU result
    SEL_MEMWB = 2'b10,  // MEM/WB result or load data
    SEL_IMM   = 2'b11   // immediate, operand B only
  } sel_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             we;
    logic             load;
  } slot_t;

  // A slot produces a value the source needs. The x0 exclusion is applied
  // by the caller because it depends on a top-level parameter.
  function automatic logic slot_match(slot_t s, logic [REG_W-1:0] src, logic use_src);
    return s.valid && s.we && (s.rd == src) && use_src;
  endfunction

endpackage

// File: rtl/hazard_slot.sv
// One shadow pipeline slot: holds {valid, rd, we, load} of the instruction
// in its stage. Freezes on hold, loads an empty record on bubble.
module hazard_slot
  import hazard_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  hold,
  input  logic  bubble,
  input  slot_t d,
  output slot_t q
);

  // Slot register: clear on reset, freeze on hold, otherwise advance.
  // NOTE: non-blocking assignment so every slot samples its neighbour's
  // pre-edge value; blocking here would let wb see ex's new value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       q <= '0;
    else if (!hold) q <= bubble ? slot_t'('0) : d;
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Operand-forwarding select generation and load-use stall detection for the
// execute stage. Tracks EX/MEM/WB producers in three shadow slots and
// registers the operand mux selects on the edge that moves ID into EX.
module forward_hazard_unit
  import hazard_pkg::*;
#(
  parameter int R         = REG_W,
  parameter bit ZERO_HARD = 1'b1,
  parameter int CW        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [R-1:0]  rs1_id,
  input  logic [R-1:0]  rs2_id,
  input  logic          rs1_use_id,
  input  logic          rs2_use_id,
  input  logic          use_imm_id,
  input  logic [R-1:0]  rd_id,
  input  logic          we_id,
  input  logic          load_id,
  input  logic          valid_id,
  input  logic          stall_ext,
  input  logic          flush,
  output logic [1:0]    sel_a,
  output logic [1:0]    sel_b,
  output logic          stall_id,
  output logic          ex_valid,
  output logic [CW-1:0] stall_cnt
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  slot_t id_slot, ex_slot, mem_slot, wb_slot;
  logic  bubble_ex;
  logic  rs1_zero, rs2_zero;
  logic  ex_m1, ex_m2, mem_m1, mem_m2;
  sel_t  sel_a_nxt, sel_b_nxt, sel_a_q, sel_b_q;
  logic [CW-1:0] stall_cnt_q;

  assign id_slot = '{valid: valid_id, rd: rd_id, we: we_id, load: load_id};

  // EX takes the ID instruction or a bubble; MEM and WB always shift.
  hazard_slot u_ex  (.clk(clk), .rst(rst), .hold(stall_ext), .bubble(bubble_ex),
                     .d(id_slot),  .q(ex_slot));
  hazard_slot u_mem (.clk(clk), .rst(rst), .hold(stall_ext), .bubble(1'b0),
                     .d(ex_slot),  .q(mem_slot));
  hazard_slot u_wb  (.clk(clk), .rst(rst), .hold(stall_ext), .bubble(1'b0),
                     .d(mem_slot), .q(wb_slot));

  // WB is tracked for completeness; the write-through register file means
  // it never forwards, and MEM's load flag never matters either.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{wb_slot, mem_slot.load};

  assign rs1_zero = ZERO_HARD && (rs1_id == '0);
  assign rs2_zero = ZERO_HARD && (rs2_id == '0);

  assign ex_m1  = slot_match(ex_slot,  rs1_id, rs1_use_id) && !rs1_zero;
  assign ex_m2  = slot_match(ex_slot,  rs2_id, rs2_use_id) && !rs2_zero;
  assign mem_m1 = slot_match(mem_slot, rs1_id, rs1_use_id) && !rs1_zero;
  assign mem_m2 = slot_match(mem_slot, rs2_id, rs2_use_id) && !rs2_zero;

  // A load in EX cannot forward in time to a dependent in ID.
  assign stall_id  = valid_id && !stall_ext && ex_slot.load &&
                     (ex_m1 || (ex_m2 && !use_imm_id));
  assign bubble_ex = flush || stall_id;

  // Select decision for the ID instruction; youngest producer wins.
  // NOTE: defaults first so every path assigns both selects and no latch
  // is inferred.
  always_comb begin
    sel_a_nxt = SEL_REG;
    sel_b_nxt = SEL_REG;
    if (valid_id) begin
      if (ex_m1)       sel_a_nxt = SEL_EXMEM;
      else if (mem_m1) sel_a_nxt = SEL_MEMWB;
      if (use_imm_id)  sel_b_nxt = SEL_IMM;
      else if (ex_m2)  sel_b_nxt = SEL_EXMEM;
      else if (mem_m2) sel_b_nxt = SEL_MEMWB;
    end
  end

  // Registered selects and saturating load-use stall counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_a_q     <= SEL_REG;
      sel_b_q     <= SEL_REG;
      stall_cnt_q <= '0;
    end else if (!stall_ext) begin
      sel_a_q <= bubble_ex ? SEL_REG : sel_a_nxt;
      sel_b_q <= bubble_ex ? SEL_REG : sel_b_nxt;
      if (stall_id && !flush && (stall_cnt_q != CNT_MAX))
        stall_cnt_q <= stall_cnt_q + CW'(1);
    end
  end

  assign sel_a     = sel_a_q;
  assign sel_b     = sel_b_q;
  assign ex_valid  = ex_slot.valid;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Self-checking bench for forward_hazard_unit: directed scenarios followed
// by randomized traffic, all compared against an in-flight producer model.
module tb_forward_hazard_unit;

  localparam int CW      = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    rs1_id, rs2_id, rd_id;
  logic          rs1_use_id, rs2_use_id, use_imm_id;
  logic          we_id, load_id, valid_id, stall_ext, flush;
  logic [1:0]    sel_a, sel_b;
  logic          stall_id, ex_valid;
  logic [CW-1:0] stall_cnt;

  forward_hazard_unit #(.R(4), .ZERO_HARD(1'b1), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_use_id(rs1_use_id), .rs2_use_id(rs2_use_id),
    .use_imm_id(use_imm_id), .rd_id(rd_id), .we_id(we_id),
    .load_id(load_id), .valid_id(valid_id),
    .stall_ext(stall_ext), .flush(flush),
    .sel_a(sel_a), .sel_b(sel_b), .stall_id(stall_id),
    .ex_valid(ex_valid), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the producers currently in flight, youngest first
  // (index 0 is in EX, index 1 in MEM), plus expected registered outputs.
  typedef struct { bit valid; int rd; bit we; bit load; } instr_t;
  instr_t flight[2];
  int m_sel_a, m_sel_b, m_cnt;
  bit m_ev, m_stalled, dut_stall_seen;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    foreach (flight[i]) flight[i] = '{0, 0, 0, 0};
    m_sel_a = 0; m_sel_b = 0; m_cnt = 0; m_ev = 0; m_stalled = 0;
  endfunction

  // Where a used source gets its value: the youngest in-flight writer.
  function automatic int fwd(int src, bit used);
    if (!used || src == 0) return 0;
    for (int age = 0; age < 2; age++)
      if (flight[age].valid && flight[age].we && flight[age].rd == src)
        return (age == 0) ? 1 : 2;
    return 0;
  endfunction

  // A load in EX whose result the ID instruction needs this cycle.
  function automatic bit model_stall();
    bit need;
    if (!valid_id || stall_ext) return 0;
    if (!(flight[0].valid && flight[0].load)) return 0;
    need = (fwd(int'(rs1_id), rs1_use_id) == 1) ||
           (!use_imm_id && fwd(int'(rs2_id), rs2_use_id) == 1);
    return need;
  endfunction

  task automatic set_id(input int rs1, input bit u1, input int rs2, input bit u2,
                        input bit imm, input int rd, input bit we, input bit ld,
                        input bit v);
    rs1_id = 4'(rs1); rs1_use_id = u1; rs2_id = 4'(rs2); rs2_use_id = u2;
    use_imm_id = imm; rd_id = 4'(rd); we_id = we; load_id = ld; valid_id = v;
  endtask

  // One pipeline cycle: check the combinational stall, advance the model,
  // clock the DUT, then check the registered outputs.
  task automatic step();
    bit es, bub;
    instr_t nxt;
    #1;
    es = model_stall();
    dut_stall_seen = stall_id;
    check("stall_id", stall_id, es);
    if (!stall_ext) begin
      bub = flush || es;
      m_sel_a = (bub || !valid_id) ? 0 : fwd(int'(rs1_id), rs1_use_id);
      m_sel_b = (bub || !valid_id) ? 0 :
                use_imm_id ? 3 : fwd(int'(rs2_id), rs2_use_id);
      m_ev = !bub && valid_id;
      if (es && !flush && m_cnt < CNT_MAX) m_cnt++;
      nxt = '{valid_id, int'(rd_id), we_id, load_id};
      if (bub) nxt = '{0, 0, 0, 0};
      flight[1] = flight[0];
      flight[0] = nxt;
    end
    m_stalled = es;
    @(posedge clk);
    #1;
    check("sel_a", sel_a, m_sel_a);
    check("sel_b", sel_b, m_sel_b);
    check("ex_valid", ex_valid, m_ev);
    check("stall_cnt", stall_cnt, m_cnt);
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  // LW x7 followed by ADD x8,x7,x2, re-presenting the ADD after the stall.
  task automatic load_use();
    set_id(1, 1, 0, 0, 1, 7, 1, 1, 1); step();
    set_id(7, 1, 2, 1, 0, 8, 1, 0, 1); step();
    step();
  endtask

  initial begin
    rst = 1'b0; stall_ext = 1'b0; flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check("rst_sel_a", sel_a, 0);
    check("rst_sel_b", sel_b, 0);
    check("rst_ex_valid", ex_valid, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_stall_id", stall_id, 0);
    @(negedge clk); rst = 1'b1;

    // Back-to-back ALU dependency forwards from EX/MEM with no stall.
    set_id(1, 1, 2, 1, 0, 3, 1, 0, 1); step();
    set_id(3, 1, 4, 1, 0, 5, 1, 0, 1); step();
    check("alu_alu_stall", dut_stall_seen, 0);
    check("alu_alu_sel_a", sel_a, 1);
    check("alu_alu_sel_b", sel_b, 0);

    // Producer two ahead forwards from MEM/WB.
    set_id(1, 1, 2, 1, 0, 3, 1, 0, 1); step();
    nop();
    set_id(1, 1, 3, 1, 0, 6, 1, 0, 1); step();
    check("gap1_sel_a", sel_a, 0);
    check("gap1_sel_b", sel_b, 2);

    // Load-use: one bubble, then MEM/WB forwarding.
    set_id(1, 1, 0, 0, 1, 7, 1, 1, 1); step();
    set_id(7, 1, 2, 1, 0, 8, 1, 0, 1); step();
    check("lu_stall", dut_stall_seen, 1);
    check("lu_bubble_ev", ex_valid, 0);
    step();
    check("lu_after_stall", dut_stall_seen, 0);
    check("lu_sel_a", sel_a, 2);
    check("lu_cnt", stall_cnt, 1);

    // x0 writers never forward; youngest x9 producer wins; immediate wins.
    set_id(1, 1, 2, 1, 0, 0, 1, 0, 1); step();
    set_id(1, 1, 2, 1, 0, 0, 1, 0, 1); step();
    set_id(0, 1, 0, 1, 0, 4, 1, 0, 1); step();
    check("x0_sel_a", sel_a, 0);
    check("x0_sel_b", sel_b, 0);
    set_id(1, 1, 2, 1, 0, 9, 1, 0, 1); step();
    set_id(2, 1, 1, 1, 0, 9, 1, 0, 1); step();
    set_id(9, 1, 9, 1, 1, 10, 1, 0, 1); step();
    check("young_sel_a", sel_a, 1);
    check("imm_sel_b", sel_b, 3);

    // Freeze during a pending load-use, with a flush ignored under freeze.
    set_id(1, 1, 0, 0, 1, 7, 1, 1, 1); step();
    set_id(7, 1, 2, 1, 0, 8, 1, 0, 1);
    stall_ext = 1'b1;
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1);
      step();
      check("freeze_stall_id", dut_stall_seen, 0);
    end
    stall_ext = 1'b0; flush = 1'b0;
    step();
    check("release_stall", dut_stall_seen, 1);
    step();
    check("release_once", dut_stall_seen, 0);
    check("release_sel_a", sel_a, 2);

    // Flush alone turns the entering instruction into a bubble.
    set_id(8, 1, 8, 1, 0, 11, 1, 0, 1);
    flush = 1'b1; step(); flush = 1'b0;
    check("flush_ev", ex_valid, 0);
    check("flush_sel_a", sel_a, 0);
    check("flush_sel_b", sel_b, 0);

    // Asynchronous reset mid-stream with the counter at 5 and slots valid.
    while (m_cnt < 5) load_use();
    set_id(1, 1, 2, 1, 0, 7, 1, 1, 1); step();
    set_id(7, 1, 7, 1, 0, 12, 1, 0, 1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_sel_a", sel_a, 0);
    check("mid_rst_sel_b", sel_b, 0);
    check("mid_rst_ex_valid", ex_valid, 0);
    check("mid_rst_cnt", stall_cnt, 0);
    check("mid_rst_stall_id", stall_id, 0);
    model_reset();
    @(negedge clk); rst = 1'b1;

    // Randomized traffic; ID holds its instruction while stalled or frozen.
    nop();
    for (int n = 0; n < 600; n++) begin
      if (!(m_stalled || stall_ext))
        set_id($urandom_range(0, 7), $urandom_range(0, 3) != 0,
               $urandom_range(0, 7), $urandom_range(0, 3) != 0,
               $urandom_range(0, 4) == 0, $urandom_range(0, 7),
               $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 9) != 0);
      stall_ext = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 11) == 0);
      step();
    end
    stall_ext = 1'b0; flush = 1'b0;

    // Drive the counter into saturation and past it.
    while (m_cnt < CNT_MAX) load_use();
    check("sat_cnt", stall_cnt, CNT_MAX);
    load_use();
    check("sat_hold_stall", m_stalled, 0);
    check("sat_hold_cnt", stall_cnt, CNT_MAX);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
